regwrite_queue: RTL and testbench

Buffers architectural-register write requests from the execute/writeback units and drains them, one per cycle in program order, into the regfile's single write port. Accepts up to `IN_PORTS` `w_req_t` per cycle and presents one `w_req_t` per cycle to the regfile. Provides a forwarding lookup so readers see writes still queued and not yet visible in the regfile array.

---
 rtl/regfile_pkg.sv | 26 ++
 rtl/regwrite_queue_if.sv | 28 ++
 rtl/regwrite_queue_lookup.sv | 35 +++
 rtl/regwrite_queue.sv | 103 ++++++++++
 tb/tb_regwrite_queue.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file types plus the write-queue defaults.
package regfile_pkg;

    localparam int AREG_W = 5;
    localparam int WORD_W = 32;

    typedef logic [AREG_W-1:0] areg_addr_t;
    typedef logic [WORD_W-1:0] word_t;

    typedef struct packed {
        logic       valid;
        areg_addr_t id;
        word_t      data;
    } w_req_t;

    localparam int REGWQ_DEPTH    = 8;
    localparam int REGWQ_IN_PORTS = 2;

    typedef logic [$clog2(REGWQ_DEPTH)-1:0] regwq_ptr_t;

    // Writes to the hardwired zero register carry no architectural effect.
    function automatic logic regwq_accept(w_req_t r);
        return r.valid && (r.id != '0);
    endfunction

endpackage

// File: rtl/regwrite_queue_if.sv
// Bundle between writeback producers, the regfile write port and readers.
interface regwrite_queue_if
    import regfile_pkg::*;
#(
    parameter int DEPTH    = REGWQ_DEPTH,
    parameter int IN_PORTS = REGWQ_IN_PORTS
);

    w_req_t                 in_req [IN_PORTS];
    logic                   in_ready;
    logic                   flush;
    w_req_t                 out_req;
    areg_addr_t             lookup_id;
    logic                   lookup_hit;
    word_t                  lookup_data;
    logic [$clog2(DEPTH):0] count;

    modport master (
        output in_req, flush, lookup_id,
        input  in_ready, out_req, lookup_hit, lookup_data, count
    );

    modport slave (
        input  in_req, flush, lookup_id,
        output in_ready, out_req, lookup_hit, lookup_data, count
    );

endinterface

// File: rtl/regwrite_queue_lookup.sv
// Forwarding search: youngest occupied entry whose id matches lookup_id.
module regwrite_queue_lookup
    import regfile_pkg::*;
#(
    parameter int DEPTH = REGWQ_DEPTH
) (
    input  w_req_t                  entries [DEPTH],
    input  logic [$clog2(DEPTH)-1:0] head,
    input  logic [$clog2(DEPTH):0]   count,
    input  areg_addr_t              lookup_id,
    output logic                    hit,
    output word_t                   data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    // Walk oldest to youngest so later matches override earlier ones.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((lookup_id != '0) && (cnt_t'(k) < count)
                && entries[head + ptr_t'(k)].valid
                && (entries[head + ptr_t'(k)].id == lookup_id)) begin
                hit  = 1'b1;
                data = entries[head + ptr_t'(k)].data;
            end
        end
    end

endmodule

// File: rtl/regwrite_queue.sv
// In-order register write queue: multi-port enqueue, single-port drain,
// with forwarding of still-queued writes.
module regwrite_queue
    import regfile_pkg::*;
#(
    parameter int DEPTH    = REGWQ_DEPTH,
    parameter int IN_PORTS = REGWQ_IN_PORTS
) (
    input logic              clk,
    input logic              resetn,
    regwrite_queue_if.slave  bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    ptr_t                head;
    ptr_t                tail;
    cnt_t                count_q;
    w_req_t              mem [DEPTH];

    logic                ready;
    logic [IN_PORTS-1:0] acc;
    ptr_t                slot [IN_PORTS];
    cnt_t                push_cnt;
    logic                pop;
    w_req_t              out_q;
    logic                hit_raw;
    word_t               data_raw;

    // Conservative: ignores the same-cycle pop, so no input-to-ready path.
    assign ready = (count_q <= cnt_t'(DEPTH - IN_PORTS));

    // Compact accepted requests onto consecutive tail slots in port order.
    always_comb begin
        push_cnt = '0;
        for (int i = 0; i < IN_PORTS; i++) begin
            acc[i]  = regwq_accept(bus.in_req[i]) && ready && !bus.flush;
            slot[i] = tail + ptr_t'(push_cnt);
            if (acc[i]) begin
                push_cnt = push_cnt + cnt_t'(1);
            end
        end
    end

    assign pop = (count_q != '0) && !bus.flush;

    // Pointers and occupancy; flush clears everything at the edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else if (bus.flush) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            head    <= head + ptr_t'(pop);
            tail    <= tail + ptr_t'(push_cnt);
            count_q <= count_q - cnt_t'(pop) + push_cnt;
        end
    end

    // Entry storage; contents are only meaningful inside [head, head+count).
    always_ff @(posedge clk) begin
        for (int i = 0; i < IN_PORTS; i++) begin
            if (acc[i]) begin
                mem[slot[i]] <= bus.in_req[i];
            end
        end
    end

    // Head entry to the regfile; all zeros whenever nothing is drained.
    always_comb begin
        out_q = '0;
        if (pop) begin
            out_q       = mem[head];
            out_q.valid = 1'b1;
        end
    end

    regwrite_queue_lookup #(
        .DEPTH (DEPTH)
    ) u_lookup (
        .entries   (mem),
        .head      (head),
        .count     (count_q),
        .lookup_id (bus.lookup_id),
        .hit       (hit_raw),
        .data      (data_raw)
    );

    assign bus.in_ready    = ready;
    assign bus.count       = count_q;
    assign bus.out_req     = out_q;
    assign bus.lookup_hit  = hit_raw && !bus.flush;
    assign bus.lookup_data = bus.flush ? '0 : data_raw;

endmodule

// File: tb/tb_regwrite_queue.sv
// Directed bench for regwrite_queue: vector table plus multi-cycle sequences.
module tb_regwrite_queue;
    import regfile_pkg::*;

    typedef struct {
        w_req_t r0;
        w_req_t r1;
        logic   fl;
        int     lid;
        logic   ev;
        int     eid;
        int     ed;
        int     ec;
        logic   er;
        logic   eh;
        int     eld;
    } vec_t;

    localparam w_req_t NONE = '0;

    logic clk;
    logic resetn;
    int   total = 0;
    int   bad   = 0;

    regwrite_queue_if #(.DEPTH(8), .IN_PORTS(2)) bus();

    regwrite_queue #(.DEPTH(8), .IN_PORTS(2)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic w_req_t R(logic v, int id, int d);
        w_req_t r;
        r.valid = v;
        r.id    = areg_addr_t'(id);
        r.data  = word_t'(d);
        return r;
    endfunction

    function automatic vec_t V(w_req_t a, w_req_t b, logic fl, int lid,
                               logic ev, int eid, int ed, int ec,
                               logic er, logic eh, int eld);
        vec_t t;
        t.r0 = a;   t.r1 = b;   t.fl = fl;  t.lid = lid;
        t.ev = ev;  t.eid = eid; t.ed = ed; t.ec = ec;
        t.er = er;  t.eh = eh;  t.eld = eld;
        return t;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(w_req_t a, w_req_t b, logic fl, int lid);
        bus.in_req[0] = a;
        bus.in_req[1] = b;
        bus.flush     = fl;
        bus.lookup_id = areg_addr_t'(lid);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[$];

    initial begin
        w_req_t sb[$];
        w_req_t a, b, tmp, exp_o;
        int     cnt, n, peak, pushed;
        bit     saw_block;

        resetn = 1'b0;
        drive(NONE, NONE, 1'b0, 0);

        // rows: inputs (r0, r1, flush, lookup_id) | expected out_req, count, in_ready, hit, data
        tbl.push_back(V(R(1,3,'hA), R(1,5,'hB), 0, 0,   0, 0, 0,    0, 1, 0, 0));
        tbl.push_back(V(NONE, NONE, 0, 5,               1, 3, 'hA,  2, 1, 1, 'hB));
        tbl.push_back(V(NONE, NONE, 0, 3,               1, 5, 'hB,  1, 1, 0, 0));
        tbl.push_back(V(R(1,0,'h1), R(1,7,'h2), 0, 7,   0, 0, 0,    0, 1, 0, 0));
        tbl.push_back(V(NONE, NONE, 0, 7,               1, 7, 'h2,  1, 1, 1, 'h2));
        tbl.push_back(V(R(1,4,'h10), R(1,4,'h20), 0, 0, 0, 0, 0,    0, 1, 0, 0));
        tbl.push_back(V(NONE, NONE, 0, 4,               1, 4, 'h10, 2, 1, 1, 'h20));
        tbl.push_back(V(NONE, NONE, 0, 4,               1, 4, 'h20, 1, 1, 1, 'h20));
        tbl.push_back(V(R(0,9,'h99), R(1,10,'h33), 0, 4, 0, 0, 0,   0, 1, 0, 0));
        tbl.push_back(V(R(1,12,'h44), R(1,13,'h55), 0, 9, 1, 10, 'h33, 1, 1, 0, 0));
        tbl.push_back(V(NONE, NONE, 0, 13,              1, 12, 'h44, 2, 1, 1, 'h55));
        tbl.push_back(V(NONE, NONE, 0, 12,              1, 13, 'h55, 1, 1, 0, 0));
        tbl.push_back(V(NONE, NONE, 0, 13,              0, 0, 0,    0, 1, 0, 0));

        // reset state
        #12;
        chk("rst_count",  64'(bus.count), 64'(0));
        chk("rst_ready",  64'(bus.in_ready), 64'(1));
        chk("rst_out",    64'(bus.out_req), 64'(0));
        chk("rst_hit",    64'(bus.lookup_hit), 64'(0));
        chk("rst_ldata",  64'(bus.lookup_data), 64'(0));
        @(negedge clk);
        resetn = 1'b1;
        tick();

        // table: ordering, $0/invalid compaction, forwarding, overlap push/pop
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].r0, tbl[i].r1, tbl[i].fl, tbl[i].lid);
            #1;
            exp_o = tbl[i].ev ? R(1, tbl[i].eid, tbl[i].ed) : NONE;
            chk($sformatf("row%0d_out", i),   64'(bus.out_req), 64'(exp_o));
            chk($sformatf("row%0d_count", i), 64'(bus.count), 64'(tbl[i].ec));
            chk($sformatf("row%0d_ready", i), 64'(bus.in_ready), 64'(tbl[i].er));
            chk($sformatf("row%0d_hit", i),   64'(bus.lookup_hit), 64'(tbl[i].eh));
            chk($sformatf("row%0d_ldata", i), 64'(bus.lookup_data), 64'(tbl[i].eld));
            tick();
        end
        drive(NONE, NONE, 1'b0, 0);

        // fill and wrap: two per cycle for 8 cycles while in_ready, then drain
        cnt = 0; n = 0; peak = 0; saw_block = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            bit exp_rdy;
            exp_rdy = (8 - cnt) >= 2;
            exp_o   = (cnt > 0) ? sb[0] : NONE;
            chk("fill_count", 64'(bus.count), 64'(cnt));
            chk("fill_ready", 64'(bus.in_ready), 64'(exp_rdy));
            chk("fill_out",   64'(bus.out_req), 64'(exp_o));
            if (!exp_rdy) saw_block = 1;
            pushed = 0;
            if (cyc < 8 && exp_rdy) begin
                a = R(1, (n % 30) + 1, 'h1000 + n);
                b = R(1, ((n + 1) % 30) + 1, 'h1001 + n);
                drive(a, b, 1'b0, 0);
                sb.push_back(a);
                sb.push_back(b);
                n += 2;
                pushed = 2;
            end else begin
                drive(NONE, NONE, 1'b0, 0);
            end
            tick();
            if (cnt > 0) begin
                tmp = sb.pop_front();
                cnt--;
            end
            cnt += pushed;
            if (cnt > peak) peak = cnt;
            if (cyc >= 8 && cnt == 0) break;
        end
        drive(NONE, NONE, 1'b0, 0);
        chk("fill_peak",    64'(peak), 64'(7));
        chk("fill_blocked", 64'(saw_block), 64'(1));
        chk("fill_drained", 64'(bus.count), 64'(0));
        chk("fill_idle",    64'(bus.out_req), 64'(0));

        // flush with count=5 and valid inputs presented
        drive(R(1,20,'h200), R(1,21,'h201), 1'b0, 0); tick();
        drive(R(1,22,'h202), R(1,23,'h203), 1'b0, 0); tick();
        drive(R(1,24,'h204), R(1,25,'h205), 1'b0, 0); tick();
        drive(R(1,26,'h206), R(1,27,'h207), 1'b0, 0); tick();
        drive(R(1,28,'h208), R(1,29,'h209), 1'b1, 27);
        #1;
        chk("flush_pre_count", 64'(bus.count), 64'(5));
        chk("flush_cyc_out",   64'(bus.out_req), 64'(0));
        chk("flush_cyc_hit",   64'(bus.lookup_hit), 64'(0));
        chk("flush_cyc_ldata", 64'(bus.lookup_data), 64'(0));
        tick();
        drive(NONE, NONE, 1'b0, 28);
        #1;
        chk("flush_count", 64'(bus.count), 64'(0));
        chk("flush_out",   64'(bus.out_req), 64'(0));
        chk("flush_ready", 64'(bus.in_ready), 64'(1));
        chk("flush_hit",   64'(bus.lookup_hit), 64'(0));
        tick();
        chk("flush_count2", 64'(bus.count), 64'(0));

        // asynchronous reset in the middle of a cycle
        drive(R(1,30,'h300), R(1,31,'h301), 1'b0, 31);
        tick();
        drive(NONE, NONE, 1'b0, 31);
        #1;
        chk("arst_pre_count", 64'(bus.count), 64'(2));
        chk("arst_pre_hit",   64'(bus.lookup_hit), 64'(1));
        #1;
        resetn = 1'b0;
        #1;
        chk("arst_count", 64'(bus.count), 64'(0));
        chk("arst_out",   64'(bus.out_req), 64'(0));
        chk("arst_hit",   64'(bus.lookup_hit), 64'(0));
        chk("arst_ldata", 64'(bus.lookup_data), 64'(0));
        chk("arst_ready", 64'(bus.in_ready), 64'(1));
        @(negedge clk);
        resetn = 1'b1;
        tick();
        chk("arst_post_count", 64'(bus.count), 64'(0));
        chk("arst_post_out",   64'(bus.out_req), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
